// File: rtl/input_buffer_fifo_if.sv
// Handshake bundle between the upstream router, the input buffer and the output flow-control stage.
// Error flags exist only when INBUF_ERR_EN is defined.
interface input_buffer_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
);
  logic                  val_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ret;
  logic                  read;
  logic                  empty;
  logic [DATA_WIDTH-1:0] data_out;
  logic [ADDR_WIDTH:0]   count;
`ifdef INBUF_ERR_EN
  logic                  overflow_err;
  logic                  underflow_err;
`endif

  modport master (
    output val_in, data_in, read,
    input  ret, empty, data_out, count
`ifdef INBUF_ERR_EN
    , input overflow_err, underflow_err
`endif
  );

  modport slave (
    input  val_in, data_in, read,
    output ret, empty, data_out, count
`ifdef INBUF_ERR_EN
    , output overflow_err, underflow_err
`endif
  );
endinterface

// File: rtl/input_buffer_fifo.sv
// Router input-port FWFT buffer with val/ret upstream handshake and read-pop downstream.
// Optional sticky overflow/underflow flags are built when INBUF_ERR_EN is defined.
module input_buffer_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input logic                clk,
  input logic                rst_n,
  input_buffer_fifo_if.slave bus
);
  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_s;
  logic                  empty_s;
  logic                  do_rd_s;
  logic                  wr_en_s;

  assign full_s  = (count_q == FULL_CNT);
  assign empty_s = (count_q == '0);
  // A pop at full frees a slot in the same edge, so a simultaneous write is accepted.
  assign do_rd_s = bus.read && !empty_s;
  assign wr_en_s = bus.val_in && (!full_s || do_rd_s);

  // Next-state pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_rd_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, do_rd_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Flit storage; cleared on reset so data_out reads zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.empty    = empty_s;
  assign bus.ret      = full_s;
  assign bus.count    = count_q;
  assign bus.data_out = mem_q[rd_ptr_q];

`ifdef INBUF_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error detection.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.val_in && full_s && !do_rd_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
    if (bus.read && empty_s) begin
      underflow_d = 1'b1;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // Error flag registers, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow_err  = overflow_q;
  assign bus.underflow_err = underflow_q;
`endif
endmodule

// File: tb/tb_input_buffer_fifo.sv
// Directed self-checking bench for input_buffer_fifo; inputs change on the falling edge,
// outputs are checked on the falling edge (or 1 time unit after driving for same-cycle values).
module tb_input_buffer_fifo;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  input_buffer_fifo_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) bus ();

  input_buffer_fifo #(.DATA_WIDTH(32), .DEPTH(4), .ADDR_WIDTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic r);
    bus.val_in  = v;
    bus.data_in = d;
    bus.read    = r;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] wrap_exp [6];
    wrap_exp[0] = 32'hA2; wrap_exp[1] = 32'hA3; wrap_exp[2] = 32'hA4;
    wrap_exp[3] = 32'hB0; wrap_exp[4] = 32'hC1; wrap_exp[5] = 32'hC2;

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tick(); tick();
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_ret", 32'(bus.ret), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_data", bus.data_out, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_empty", 32'(bus.empty), 32'd1);

    // Fill with A1..A4
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hA1 + 32'(i), 1'b0);
      tick();
      chk("fill_count", 32'(bus.count), 32'(i + 1));
      chk("fill_head", bus.data_out, 32'hA1);
      chk("fill_empty", 32'(bus.empty), 32'd0);
      chk("fill_ret", 32'(bus.ret), (i == 3) ? 32'd1 : 32'd0);
    end

    // Drain four with zero-latency head
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      chk("drain_head", bus.data_out, 32'hA1 + 32'(i));
      tick();
      chk("drain_ret", 32'(bus.ret), 32'd0);
      chk("drain_count", 32'(bus.count), 32'(3 - i));
      chk("drain_empty", 32'(bus.empty), (i == 3) ? 32'd1 : 32'd0);
    end

    // Empty: read alone ignored
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("empty_rd_count", 32'(bus.count), 32'd0);
`ifdef INBUF_ERR_EN
    chk("underflow_set", 32'(bus.underflow_err), 32'd1);
    chk("overflow_clear", 32'(bus.overflow_err), 32'd0);
`endif

    // Empty: simultaneous write and read -> write only
    drive(1'b1, 32'h55, 1'b1);
    tick();
    chk("empty_wr_rd_count", 32'(bus.count), 32'd1);
    chk("empty_wr_rd_head", bus.data_out, 32'h55);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("pop55_empty", 32'(bus.empty), 32'd1);

    // Refill A1..A4 (pointers now at 1)
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hA1 + 32'(i), 1'b0);
      tick();
    end
    chk("refill_ret", 32'(bus.ret), 32'd1);

    // Full: write without read is dropped
    drive(1'b1, 32'hDD, 1'b0);
    tick();
    chk("drop_count", 32'(bus.count), 32'd4);
    chk("drop_head", bus.data_out, 32'hA1);
`ifdef INBUF_ERR_EN
    chk("overflow_set", 32'(bus.overflow_err), 32'd1);
`endif

    // Full: simultaneous write and read
    drive(1'b1, 32'hB0, 1'b1);
    chk("full_wr_rd_head_pre", bus.data_out, 32'hA1);
    tick();
    chk("full_wr_rd_count", 32'(bus.count), 32'd4);
    chk("full_wr_rd_head", bus.data_out, 32'hA2);

    // Drain six across the wrap, pushing C1, C2 during the first two pops
    for (int i = 0; i < 6; i++) begin
      if (i < 2) drive(1'b1, 32'hC1 + 32'(i), 1'b1);
      else       drive(1'b0, 32'h0, 1'b1);
      chk("wrap_head", bus.data_out, wrap_exp[i]);
      tick();
      chk("wrap_count", 32'(bus.count), (i < 2) ? 32'd4 : 32'(5 - i));
    end
    chk("wrap_empty", 32'(bus.empty), 32'd1);
`ifdef INBUF_ERR_EN
    chk("overflow_sticky", 32'(bus.overflow_err), 32'd1);
    chk("underflow_sticky", 32'(bus.underflow_err), 32'd1);
`endif

    // Async reset mid-stream at count 2
    drive(1'b1, 32'h11, 1'b0);
    tick();
    drive(1'b1, 32'h22, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    chk("pre_arst_count", 32'(bus.count), 32'd2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_empty", 32'(bus.empty), 32'd1);
    chk("arst_ret", 32'(bus.ret), 32'd0);
    chk("arst_data", bus.data_out, 32'h0);
`ifdef INBUF_ERR_EN
    chk("arst_overflow", 32'(bus.overflow_err), 32'd0);
    chk("arst_underflow", 32'(bus.underflow_err), 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_arst_empty", 32'(bus.empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
